dbram_load_align: RTL

- Sits directly downstream of the local data BRAM load/store sub-unit, between its raw 32-bit read data and the writeback path.
- Records per-load attributes when a load request is issued, then aligns and sign/zero-extends the returned word.
- Buffers formatted results in order and presents them to writeback through a valid/ready handshake.
- The BRAM path cannot stall, so the block exports a credit-based req_ready; the issue logic must hold off loads while it is low.

---
 rtl/dbram_load_align.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dbram_load_align.sv
// Load-return aligner between the data BRAM and writeback: records load attributes
// at issue, formats the returned word, and queues results in order behind valid/ready.
module dbram_load_align #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_fn3,
  input  logic [1:0]      req_byte_off,
  input  logic [ID_W-1:0] req_id,
  output logic            req_ready,
  input  logic            rd_valid,
  input  logic [31:0]     rd_data,
  output logic            wb_valid,
  output logic [31:0]     wb_data,
  output logic [ID_W-1:0] wb_id,
  input  logic            wb_ready,
  output logic            err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [2:0]      fn3;
    logic [1:0]      off;
    logic [ID_W-1:0] id;
  } attr_t;

  // Byte/halfword lane select plus sign or zero extension; unknown fn3 passes the word.
  function automatic logic [31:0] format_load(input logic [2:0]  fn3,
                                               input logic [1:0]  off,
                                               input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = off[1] ? data[31:16] : data[15:0];
    case (fn3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = data;
    endcase
    return r;
  endfunction

  logic [CNT_W-1:0] occ_q,      occ_d;
  logic             req_ready_q, req_ready_d;
  attr_t            attr_mem_q [DEPTH];
  attr_t            attr_mem_d [DEPTH];
  logic [PTR_W-1:0] attr_wp_q,  attr_wp_d;
  logic [PTR_W-1:0] attr_rp_q,  attr_rp_d;
  logic [CNT_W-1:0] attr_cnt_q, attr_cnt_d;
  logic [31:0]      res_data_q [DEPTH];
  logic [31:0]      res_data_d [DEPTH];
  logic [ID_W-1:0]  res_id_q   [DEPTH];
  logic [ID_W-1:0]  res_id_d   [DEPTH];
  logic [PTR_W-1:0] res_wp_q,   res_wp_d;
  logic [PTR_W-1:0] res_rp_q,   res_rp_d;
  logic [CNT_W-1:0] res_cnt_q,  res_cnt_d;
  logic             wb_valid_q, wb_valid_d;
  logic             err_q,      err_d;

  logic             accept_s;
  logic             retire_s;
  logic             rd_ok_s;
  attr_t            head_s;
  logic [31:0]      fmt_s;

  // Next-state for occupancy, both FIFOs, sticky error and the registered handshakes.
  always_comb begin
    accept_s   = req_valid & req_ready_q;
    retire_s   = wb_valid_q & wb_ready;
    rd_ok_s    = rd_valid & (attr_cnt_q != {CNT_W{1'b0}});
    head_s     = attr_mem_q[attr_rp_q];
    fmt_s      = format_load(head_s.fn3, head_s.off, rd_data);

    occ_d      = occ_q;
    attr_mem_d = attr_mem_q;
    attr_wp_d  = attr_wp_q;
    attr_rp_d  = attr_rp_q;
    attr_cnt_d = attr_cnt_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    res_wp_d   = res_wp_q;
    res_rp_d   = res_rp_q;
    res_cnt_d  = res_cnt_q;

    case ({accept_s, retire_s})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    if (accept_s) begin
      attr_mem_d[attr_wp_q] = '{fn3: req_fn3, off: req_byte_off, id: req_id};
      attr_wp_d             = attr_wp_q + PTR_W'(1);
    end else begin
      attr_wp_d             = attr_wp_q;
    end

    if (rd_ok_s) begin
      attr_rp_d            = attr_rp_q + PTR_W'(1);
      res_data_d[res_wp_q] = fmt_s;
      res_id_d[res_wp_q]   = head_s.id;
      res_wp_d             = res_wp_q + PTR_W'(1);
    end else begin
      attr_rp_d            = attr_rp_q;
      res_wp_d             = res_wp_q;
    end

    if (retire_s) begin
      res_rp_d = res_rp_q + PTR_W'(1);
    end else begin
      res_rp_d = res_rp_q;
    end

    case ({accept_s, rd_ok_s})
      2'b10:   attr_cnt_d = attr_cnt_q + CNT_W'(1);
      2'b01:   attr_cnt_d = attr_cnt_q - CNT_W'(1);
      default: attr_cnt_d = attr_cnt_q;
    endcase

    case ({rd_ok_s, retire_s})
      2'b10:   res_cnt_d = res_cnt_q + CNT_W'(1);
      2'b01:   res_cnt_d = res_cnt_q - CNT_W'(1);
      default: res_cnt_d = res_cnt_q;
    endcase

    // Credit is computed from next occupancy so req_ready itself is a flop.
    req_ready_d = (occ_d < CNT_W'(DEPTH));
    wb_valid_d  = (res_cnt_d != {CNT_W{1'b0}});
    err_d       = err_q
                | (req_valid & ~req_ready_q)
                | (rd_valid & (attr_cnt_q == {CNT_W{1'b0}}));
  end

  // State registers; reset discards every in-flight attribute and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= {CNT_W{1'b0}};
      req_ready_q <= 1'b1;
      attr_wp_q   <= {PTR_W{1'b0}};
      attr_rp_q   <= {PTR_W{1'b0}};
      attr_cnt_q  <= {CNT_W{1'b0}};
      res_wp_q    <= {PTR_W{1'b0}};
      res_rp_q    <= {PTR_W{1'b0}};
      res_cnt_q   <= {CNT_W{1'b0}};
      wb_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        attr_mem_q[i] <= '0;
        res_data_q[i] <= 32'd0;
        res_id_q[i]   <= {ID_W{1'b0}};
      end
    end else begin
      occ_q       <= occ_d;
      req_ready_q <= req_ready_d;
      attr_wp_q   <= attr_wp_d;
      attr_rp_q   <= attr_rp_d;
      attr_cnt_q  <= attr_cnt_d;
      res_wp_q    <= res_wp_d;
      res_rp_q    <= res_rp_d;
      res_cnt_q   <= res_cnt_d;
      wb_valid_q  <= wb_valid_d;
      err_q       <= err_d;
      attr_mem_q  <= attr_mem_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign req_ready = req_ready_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = res_data_q[res_rp_q];
  assign wb_id     = res_id_q[res_rp_q];
  assign err       = err_q;

endmodule
